// File: rtl/sb_tx_msg_fifo_pkg.sv
// Shared types and constants for the sideband TX message FIFO.
// Latency: n/a (types only).
// Backpressure: n/a.
package sb_tx_fifo_pkg;

    localparam int SB_DATA_W_DEF = 64;
    localparam int SB_DEPTH_DEF  = 64;

    // Default-width entry; parametrised users declare the same shape locally with their DATA_W.
    typedef struct packed {
        logic                     no_payload;
        logic [SB_DATA_W_DEF-1:0] data;
    } sb_entry_t;

    // Pointer/occupancy width: one extra bit distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sb_tx_msg_fifo_if.sv
// Encoder/serializer-facing bundle of the sideband TX message FIFO.
// Latency: n/a (wiring only).
// Backpressure: writer watches o_full/o_almost_full, reader gates on o_empty.
interface sb_tx_msg_fifo_if
    import sb_tx_fifo_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W_DEF,
    parameter int DEPTH  = SB_DEPTH_DEF
);
    localparam int CW = ptr_w(DEPTH);

    logic              i_write_enable;
    logic [DATA_W-1:0] i_data_in;
    logic              i_no_payload;
    logic              i_delete_data;
    logic              i_read_enable;
    logic              i_flush;
    logic [DATA_W-1:0] o_data_out;
    logic              o_no_payload;
    logic              o_valid;
    logic              o_ser_done_sampled;
    logic              o_empty;
    logic              o_full;
    logic              o_almost_full;
    logic [CW-1:0]     o_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_write_enable, i_data_in, i_no_payload, i_delete_data, i_read_enable, i_flush,
        input  o_data_out, o_no_payload, o_valid, o_ser_done_sampled, o_empty, o_full,
               o_almost_full, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_write_enable, i_data_in, i_no_payload, i_delete_data, i_read_enable, i_flush,
        output o_data_out, o_no_payload, o_valid, o_ser_done_sampled, o_empty, o_full,
               o_almost_full, o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/sb_tx_msg_fifo_mem.sv
// Simple dual-port entry array: one write port, one registered read port.
// Latency: read data registered, valid one edge after i_re.
// Backpressure: none; caller guarantees address legality.
module sb_fifo_mem #(
    parameter  int W     = 65,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     o_rdata <= '0;
        else if (i_clr) o_rdata <= '0;
        else if (i_re)  o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/sb_tx_msg_fifo.sv
// Sideband TX message FIFO with replace-last, flush, occupancy and sticky error flags.
// Latency: read data and o_valid one edge after an accepted read; o_empty lags by one cycle.
// Backpressure: writes while full are dropped (o_overflow); reads/deletes on empty are ignored (o_underflow).
module sb_tx_msg_fifo
    import sb_tx_fifo_pkg::*;
#(
    parameter int DATA_W    = SB_DATA_W_DEF,
    parameter int DEPTH     = SB_DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sb_tx_msg_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    typedef struct packed {
        logic              no_payload;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [PW-1:0] wr_ptr, rd_ptr, wr_last, count;
    logic          empty_c, full;
    logic          rd_go, del_ok, wr_new, wr_rep, wr_drop, del_only;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    entry_t        wr_entry, rd_entry;
    logic          valid_q, empty_q, ser_done_q, ovf_q, unf_q;

    assign count   = wr_ptr - rd_ptr;
    assign wr_last = wr_ptr - PW'(1);
    assign empty_c = (count == '0);
    assign full    = (count == PW'(DEPTH));

    // A read draining the only entry beats a same-cycle delete of that entry.
    assign rd_go    = bus.i_read_enable & ~empty_c & ~bus.i_flush;
    assign del_ok   = bus.i_delete_data & ~empty_c & ~((count == PW'(1)) & rd_go);
    assign wr_rep   = bus.i_write_enable & del_ok;
    assign wr_new   = bus.i_write_enable & ~del_ok & ~full;
    assign wr_drop  = bus.i_write_enable & ~del_ok & full;
    assign del_only = del_ok & ~bus.i_write_enable;

    assign mem_we    = ~bus.i_flush & (wr_new | wr_rep);
    assign mem_waddr = wr_rep ? wr_last[AW-1:0] : wr_ptr[AW-1:0];
    assign wr_entry  = '{no_payload: bus.i_no_payload, data: bus.i_data_in};

    sb_fifo_mem #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (bus.i_flush),
        .i_we    (mem_we),
        .i_waddr (mem_waddr),
        .i_wdata (wr_entry),
        .i_re    (rd_go),
        .i_raddr (rd_ptr[AW-1:0]),
        .o_rdata (rd_entry)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (rd_go)         rd_ptr <= rd_ptr + PW'(1);
            if (wr_new)        wr_ptr <= wr_ptr + PW'(1);
            else if (del_only) wr_ptr <= wr_last;
            valid_q <= rd_go;
            ovf_q   <= ovf_q | wr_drop;
            unf_q   <= unf_q | (bus.i_delete_data & ~del_ok) | (bus.i_read_enable & empty_c);
        end
    end

    // Flush does not touch these: o_empty simply follows empty_c one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            empty_q    <= 1'b1;
            ser_done_q <= 1'b0;
        end else begin
            empty_q    <= empty_c;
            ser_done_q <= bus.i_read_enable;
        end
    end

    assign bus.o_data_out         = rd_entry.data;
    assign bus.o_no_payload       = rd_entry.no_payload;
    assign bus.o_valid            = valid_q;
    assign bus.o_ser_done_sampled = ser_done_q;
    assign bus.o_empty            = empty_q;
    assign bus.o_full             = full;
    assign bus.o_almost_full      = (count >= PW'(AF_THRESH));
    assign bus.o_count            = count;
    assign bus.o_overflow         = ovf_q;
    assign bus.o_underflow        = unf_q;

endmodule

// File: tb/tb_sb_tx_msg_fifo.sv
// Directed bench for sb_tx_msg_fifo (DEPTH=8, AF_THRESH=4, DATA_W=16).
// Table of per-cycle vectors plus hand sequences for fill, wrap, flush and async reset.
module tb_sb_tx_msg_fifo;

    localparam int DW = 16;
    localparam int DP = 8;

    logic i_clk;
    logic i_rst;

    sb_tx_msg_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    sb_tx_msg_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic          we;
        logic [DW-1:0] din;
        logic          np;
        logic          del;
        logic          re;
        logic          fl;
        logic [DW-1:0] e_dout;
        logic          e_np;
        logic          e_vld;
        logic          e_empty;
        logic          e_full;
        logic          e_af;
        logic [3:0]    e_cnt;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t        tbl[$];
    logic [DW-1:0] q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic v(input int we, input int din, input int np, input int del, input int re,
                     input int fl, input int dout, input int enp, input int vld, input int emp,
                     input int full, input int af, input int cnt, input int ovf, input int unf);
        vec_t t;
        t.we = 1'(we); t.din = DW'(din); t.np = 1'(np); t.del = 1'(del); t.re = 1'(re);
        t.fl = 1'(fl); t.e_dout = DW'(dout); t.e_np = 1'(enp); t.e_vld = 1'(vld);
        t.e_empty = 1'(emp); t.e_full = 1'(full); t.e_af = 1'(af); t.e_cnt = 4'(cnt);
        t.e_ovf = 1'(ovf); t.e_unf = 1'(unf);
        tbl.push_back(t);
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic we, input logic [DW-1:0] din, input logic np,
                       input logic del, input logic re, input logic fl);
        @(negedge i_clk);
        bus.i_write_enable = we;
        bus.i_data_in      = din;
        bus.i_no_payload   = np;
        bus.i_delete_data  = del;
        bus.i_read_enable  = re;
        bus.i_flush        = fl;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".dout"}, 32'(bus.o_data_out), 0);
        chk({tag, ".np"},   32'(bus.o_no_payload), 0);
        chk({tag, ".vld"},  32'(bus.o_valid), 0);
        chk({tag, ".ser"},  32'(bus.o_ser_done_sampled), 0);
        chk({tag, ".empty"}, 32'(bus.o_empty), 1);
        chk({tag, ".full"}, 32'(bus.o_full), 0);
        chk({tag, ".af"},   32'(bus.o_almost_full), 0);
        chk({tag, ".cnt"},  32'(bus.o_count), 0);
        chk({tag, ".ovf"},  32'(bus.o_overflow), 0);
        chk({tag, ".unf"},  32'(bus.o_underflow), 0);
    endtask

    initial begin
        int  c;
        logic [DW-1:0] e;

        i_rst = 1'b1;
        bus.i_write_enable = 1'b0; bus.i_data_in = '0; bus.i_no_payload = 1'b0;
        bus.i_delete_data = 1'b0; bus.i_read_enable = 1'b0; bus.i_flush = 1'b0;
        #12;
        chk_reset("rst");
        @(negedge i_clk);
        i_rst = 1'b0;

        //  we  din  np del re fl | dout np vld emp full af cnt ovf unf
        v(1, 1,    0, 0, 0, 0,   0,    0, 0,  1,  0,   0, 1,  0,  0);
        v(1, 2,    1, 0, 0, 0,   0,    0, 0,  0,  0,   0, 2,  0,  0);
        v(1, 3,    0, 0, 0, 0,   0,    0, 0,  0,  0,   0, 3,  0,  0);
        v(0, 0,    0, 0, 1, 0,   1,    0, 1,  0,  0,   0, 2,  0,  0);
        v(0, 0,    0, 0, 1, 0,   2,    1, 1,  0,  0,   0, 1,  0,  0);
        v(0, 0,    0, 0, 1, 0,   3,    0, 1,  0,  0,   0, 0,  0,  0);
        v(0, 0,    0, 0, 0, 0,   3,    0, 0,  1,  0,   0, 0,  0,  0);
        v(0, 0,    0, 0, 1, 0,   3,    0, 0,  1,  0,   0, 0,  0,  1);
        v(0, 0,    0, 0, 0, 1,   0,    0, 0,  1,  0,   0, 0,  0,  0);
        v(0, 0,    0, 1, 0, 0,   0,    0, 0,  1,  0,   0, 0,  0,  1);
        v(0, 0,    0, 0, 0, 1,   0,    0, 0,  1,  0,   0, 0,  0,  0);
        v(1, 'hA,  0, 0, 0, 0,   0,    0, 0,  1,  0,   0, 1,  0,  0);
        v(1, 'hB,  0, 0, 0, 0,   0,    0, 0,  0,  0,   0, 2,  0,  0);
        v(1, 'hC,  0, 1, 0, 0,   0,    0, 0,  0,  0,   0, 2,  0,  0);
        v(0, 0,    0, 0, 1, 0,   'hA,  0, 1,  0,  0,   0, 1,  0,  0);
        v(0, 0,    0, 0, 1, 0,   'hC,  0, 1,  0,  0,   0, 0,  0,  0);
        v(0, 0,    0, 0, 0, 0,   'hC,  0, 0,  1,  0,   0, 0,  0,  0);
        v(1, 7,    1, 0, 0, 0,   'hC,  0, 0,  1,  0,   0, 1,  0,  0);
        v(1, 8,    0, 1, 1, 0,   7,    1, 1,  0,  0,   0, 1,  0,  1);
        v(0, 0,    0, 0, 1, 0,   8,    0, 1,  0,  0,   0, 0,  0,  1);
        v(1, 5,    0, 0, 0, 0,   8,    0, 0,  1,  0,   0, 1,  0,  1);
        v(1, 6,    0, 0, 0, 0,   8,    0, 0,  0,  0,   0, 2,  0,  1);
        v(0, 0,    0, 1, 0, 0,   8,    0, 0,  0,  0,   0, 1,  0,  1);
        v(0, 0,    0, 0, 1, 0,   5,    0, 1,  0,  0,   0, 0,  0,  1);
        v(0, 0,    0, 0, 0, 1,   0,    0, 0,  1,  0,   0, 0,  0,  0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].we, tbl[i].din, tbl[i].np, tbl[i].del, tbl[i].re, tbl[i].fl);
            chk($sformatf("v%0d.dout", i),  32'(bus.o_data_out),    32'(tbl[i].e_dout));
            chk($sformatf("v%0d.np", i),    32'(bus.o_no_payload),  32'(tbl[i].e_np));
            chk($sformatf("v%0d.vld", i),   32'(bus.o_valid),       32'(tbl[i].e_vld));
            chk($sformatf("v%0d.empty", i), 32'(bus.o_empty),       32'(tbl[i].e_empty));
            chk($sformatf("v%0d.full", i),  32'(bus.o_full),        32'(tbl[i].e_full));
            chk($sformatf("v%0d.af", i),    32'(bus.o_almost_full), 32'(tbl[i].e_af));
            chk($sformatf("v%0d.cnt", i),   32'(bus.o_count),       32'(tbl[i].e_cnt));
            chk($sformatf("v%0d.ovf", i),   32'(bus.o_overflow),    32'(tbl[i].e_ovf));
            chk($sformatf("v%0d.unf", i),   32'(bus.o_underflow),   32'(tbl[i].e_unf));
        end

        // Fill past capacity: 9th write dropped.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, DW'(16'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            c = (i + 1 > DP) ? DP : i + 1;
            if (i < DP) q.push_back(DW'(16'h10 + i));
            chk($sformatf("fill%0d.cnt", i),  32'(bus.o_count), 32'(c));
            chk($sformatf("fill%0d.full", i), 32'(bus.o_full), 32'(c == DP));
            chk($sformatf("fill%0d.af", i),   32'(bus.o_almost_full), 32'(c >= 4));
            chk($sformatf("fill%0d.ovf", i),  32'(bus.o_overflow), 32'(i == 8));
        end

        // Wrap the pointers several times with concurrent read/write near full and at half.
        c = DP;
        for (int i = 0; i < 29; i++) begin
            logic rw;
            rw = (i >= 1 && i < 11) || (i >= 14 && i < 28);
            cyc(rw, DW'(16'h20 + i), 1'b0, 1'b0, 1'b1, 1'b0);
            e = q.pop_front();
            if (rw) q.push_back(DW'(16'h20 + i));
            else    c--;
            if (i == 28) c = q.size();
            chk($sformatf("wrap%0d.dout", i), 32'(bus.o_data_out), 32'(e));
            chk($sformatf("wrap%0d.vld", i),  32'(bus.o_valid), 1);
            chk($sformatf("wrap%0d.cnt", i),  32'(bus.o_count), 32'(c));
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("drain.dout", 32'(bus.o_data_out), 32'(e));
            chk("drain.cnt",  32'(bus.o_count), 32'(q.size()));
        end

        // Flush with five entries and a concurrent write (overflow still sticky from the fill).
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush.cnt", 32'(bus.o_count), 5);
        cyc(1'b1, 16'h99, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush.cnt",  32'(bus.o_count), 0);
        chk("flush.ovf",  32'(bus.o_overflow), 0);
        chk("flush.unf",  32'(bus.o_underflow), 0);
        chk("flush.dout", 32'(bus.o_data_out), 0);
        chk("flush.vld",  32'(bus.o_valid), 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_flush.empty", 32'(bus.o_empty), 1);
        chk("post_flush.cnt",   32'(bus.o_count), 0);

        // Async reset in the middle of a burst.
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'h61 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h64, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("burst.dout", 32'(bus.o_data_out), 32'h61);
        chk("burst.ser",  32'(bus.o_ser_done_sampled), 1);
        chk("burst.cnt",  32'(bus.o_count), 3);
        #2;
        i_rst = 1'b1;
        #1;
        chk_reset("arst");
        @(negedge i_clk);
        bus.i_write_enable = 1'b0;
        bus.i_read_enable  = 1'b0;
        i_rst = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_rst.cnt", 32'(bus.o_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_tx_msg_fifo.md
# sb_tx_msg_fifo

Parametrised sideband transmit message FIFO; next-generation replacement for the fixed 64x64 sideband TX buffer. Sits between the sideband message encoder (writer) and the sideband serializer (reader). Adds configurable width/depth, a per-entry no-payload tag replacing all-zero data detection, replace-last-entry, flush, occupancy/almost-full reporting, and sticky error flags.

## Interface
Parameters:
- DATA_W, 64, entry width in bits
- DEPTH, 64, entry count; power of two, >= 4
- AF_THRESH, DEPTH-4, o_almost_full asserts when count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock (sideband clock domain)
- i_rst  in  1  asynchronous, active-high reset
- i_write_enable  in  1  write request
- i_data_in  in  DATA_W  write data
- i_no_payload  in  1  tag stored with entry: message carries no data phase
- i_delete_data  in  1  remove the most recently written entry
- i_read_enable  in  1  read request from serializer
- i_flush  in  1  synchronous clear of contents and flags
- o_data_out  out  DATA_W  registered read data
- o_no_payload  out  1  registered tag of o_data_out
- o_valid  out  1  one-cycle pulse: o_data_out/o_no_payload updated by the previous edge
- o_ser_done_sampled  out  1  i_read_enable delayed one cycle
- o_empty  out  1  registered empty flag
- o_full  out  1  combinational full flag
- o_almost_full  out  1  combinational, count >= AF_THRESH
- o_count  out  $clog2(DEPTH)+1  combinational occupancy
- o_overflow  out  1  sticky: write dropped because full
- o_underflow  out  1  sticky: read or delete with nothing to remove

## Operation
- Pointers wr_ptr, rd_ptr are $clog2(DEPTH)+1 bits, wrap naturally; count = wr_ptr - rd_ptr (modulo width). empty_c = (count==0); full = (count==DEPTH).
- Priority per edge: i_flush > delete/write group; read evaluated independently on pre-edge state.
- Flush: wr_ptr, rd_ptr, o_data_out, o_no_payload, o_valid, o_overflow, o_underflow -> 0; memory untouched; concurrent write/read/delete ignored.
- Write only (no delete): if ~full, store {i_no_payload, i_data_in} at wr_ptr, wr_ptr+1; if full, drop and set o_overflow. A same-cycle read does not free space for the write.
- Delete only: if count > 0, wr_ptr-1; else set o_underflow.
- Delete + write: if count > 0, overwrite entry at wr_ptr-1 (replace last), wr_ptr unchanged; if count==0, delete ignored, o_underflow set, write proceeds normally.
- Delete when count==1 and a read takes that entry the same cycle: read wins, delete ignored, o_underflow set; with concurrent write, write is stored as a new entry.
- Read: if ~empty_c, o_data_out/o_no_payload <= mem[rd_ptr], rd_ptr+1, o_valid=1 next cycle; if empty_c, outputs hold, o_valid=0, o_underflow set. No write-to-read bypass.
- Simultaneous accepted read and write: count unchanged.
- Memory not reset.

## Timing
- Reset values: o_data_out=0, o_no_payload=0, o_valid=0, o_ser_done_sampled=0, o_empty=1, o_full=0, o_almost_full=0, o_count=0, o_overflow=0, o_underflow=0.
- Read latency: 1 cycle, request at edge N -> data valid after edge N, o_valid high cycle N..N+1.
- Write at edge N: o_count/o_full/o_almost_full update after N; o_empty deasserts after N+1 (registered from empty_c).
- o_empty lags empty_c by one cycle; reader gates on o_empty, FIFO gates internally on empty_c.
- Reset asserted mid-operation: immediate async clear of pointers and all registered outputs.

## Structure
- Package sb_tx_fifo_pkg: entry struct {logic no_payload; logic [DATA_W-1:0] data} as parametrised typedef helper, default DATA_W/DEPTH constants, pointer-width function.
- Sub-module sb_fifo_mem: simple dual-port register array (one write port, one registered read port); top holds pointers, control, flags.

## Test plan
- Reset, write 3 entries (0x1,0x2,0x3, tags 0,1,0), read 3 -> o_data_out 0x1/0x2/0x3, o_no_payload 0/1/0, o_valid pulse each, o_empty=1 two cycles after last read.
- DEPTH=8: write 9 entries -> o_full after 8th, 9th dropped, o_overflow=1, o_count=8; o_almost_full at count 4 (AF_THRESH=4).
- Write 0xA,0xB, then delete+write 0xC -> o_count=2, reads return 0xA,0xC.
- Delete with count=0 and read with count=0 -> o_underflow=1, pointers unchanged, o_data_out holds.
- Fill, wrap 3x with concurrent read/write at full and half-full -> data order preserved, o_count constant during concurrent ops.
- Flush with 5 entries plus concurrent write -> o_count=0, flags cleared, o_data_out=0; async i_rst mid-burst -> all outputs to reset values same cycle.
